// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: one state per clock, Moore strobes from the current state,
// memory ready handshake with timeout, retired-instruction counter and sticky trap flags.
module mips_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret,
  output logic             illegal_op,
  output logic             bus_error
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StRExec   = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StIExec   = 4'd10,
    StIWb     = 4'd11,
    StTrap    = 4'd12
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [5:0]       opcode_q;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] instret_q;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  logic             waiting, timeout;

  // Branch condition is resolved in the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  assign waiting = (state_q == StFetch || state_q == StMemRd || state_q == StMemWr) && !mem_ready;
  // The limit-th stalled cycle traps; a ready in that same cycle completes normally.
  assign timeout = waiting && (wait_q == WaitLast);

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    bus_err_d = bus_err_q;
    unique case (state_q)
      StFetch: begin
        if (mem_ready) state_d = StDecode;
        else if (timeout) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end
      end
      StDecode: begin
        unique case (opcode)
          OpR:        state_d = StRExec;
          OpLw, OpSw: state_d = StMemAddr;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StIExec;
          default: begin
            state_d   = StTrap;
            illegal_d = 1'b1;
          end
        endcase
      end
      StMemAddr: state_d = (opcode_q == OpLw) ? StMemRd : StMemWr;
      StMemRd, StMemWr: begin
        if (mem_ready) state_d = (state_q == StMemRd) ? StMemWb : StFetch;
        else if (timeout) begin
          state_d   = StTrap;
          bus_err_d = 1'b1;
        end
      end
      StRExec:  state_d = StRWb;
      StIExec:  state_d = StIWb;
      StMemWb, StRWb, StIWb, StBranch, StJump: state_d = StFetch;
      default:  state_d = StTrap;
    endcase
    wait_d = (state_d != state_q) ? 8'd0 : (waiting ? wait_q + 8'd1 : wait_q);
  end

  // Strobes are forced low while reset is held so an aborted instruction issues nothing.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    pc_source     = 2'd0;
    instr_done    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        StFetch: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          pc_write  = mem_ready;
          ir_write  = mem_ready;
        end
        StDecode:  alu_src_b = 2'd3;
        StMemAddr: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        StMemRd: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        StMemWb: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        StMemWr: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        StRExec: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd2;
        end
        StRWb: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        StBranch: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'd1;
          pc_write_cond = 1'b1;
          pc_source     = 2'd1;
          instr_done    = 1'b1;
        end
        StJump: begin
          pc_write   = 1'b1;
          pc_source  = 2'd2;
          instr_done = 1'b1;
        end
        StIExec: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        StIWb: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StFetch;
      opcode_q  <= 6'd0;
      wait_q    <= 8'd0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
      if (state_q == StDecode) opcode_q <= opcode;
      if (instr_done) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign state      = state_q;
  assign instret    = instret_q;
  assign illegal_op = illegal_q;
  assign bus_error  = bus_err_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized self-checking bench for mips_multicycle_ctrl against a per-instruction path model.
module tb_mips_multicycle_ctrl;

  localparam int unsigned CntW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [5:0]      opcode = 6'd0;
  logic            zero = 1'b0;
  logic            mem_ready = 1'b0;
  logic            pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic            mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op, bus_error;
  logic [1:0]      alu_src_b, alu_op, pc_source;
  logic [3:0]      state;
  logic [CntW-1:0] instret;

  int total = 0;
  int bad = 0;
  int unsigned model_instret = 0;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CntW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .instr_done(instr_done), .instret(instret),
    .illegal_op(illegal_op), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  logic [16:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                 reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done};

  // Expected strobe word for a state number, straight from the per-state control table.
  function automatic logic [16:0] exp_ctrl(input int st, input logic rdy);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, done;
    logic [1:0] sb, op, ps;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, done} = '0;
    sb = 2'd0; op = 2'd0; ps = 2'd0;
    case (st)
      0:  begin mr = 1; sb = 2'd1; pw = rdy; irw = rdy; end
      1:  sb = 2'd3;
      2:  begin sa = 1; sb = 2'd2; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; done = 1; end
      5:  begin mw = 1; iod = 1; done = rdy; end
      6:  begin sa = 1; op = 2'd2; end
      7:  begin rw = 1; rd = 1; done = 1; end
      8:  begin sa = 1; op = 2'd1; pwc = 1; ps = 2'd1; done = 1; end
      9:  begin pw = 1; ps = 2'd2; done = 1; end
      10: begin sa = 1; sb = 2'd2; end
      11: begin rw = 1; done = 1; end
      default: ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, done};
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    #2;
    rst_n = 1'b1;
    model_instret = 0;
  endtask

  // Runs one legal instruction from FETCH: fw stalls in FETCH, mw stalls in the memory state.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input string name);
    int sts[$];
    logic rdys[$];
    for (int i = 0; i < fw; i++) begin sts.push_back(0); rdys.push_back(1'b0); end
    sts.push_back(0); rdys.push_back(1'b1);
    sts.push_back(1); rdys.push_back(1'($urandom));
    case (op)
      6'b000000: begin
        sts.push_back(6); rdys.push_back(1'($urandom));
        sts.push_back(7); rdys.push_back(1'($urandom));
      end
      6'b100011, 6'b101011: begin
        sts.push_back(2); rdys.push_back(1'($urandom));
        for (int i = 0; i < mw; i++) begin
          sts.push_back(op[3] ? 5 : 3); rdys.push_back(1'b0);
        end
        sts.push_back(op[3] ? 5 : 3); rdys.push_back(1'b1);
        if (!op[3]) begin sts.push_back(4); rdys.push_back(1'($urandom)); end
      end
      6'b000100: begin sts.push_back(8); rdys.push_back(1'($urandom)); end
      6'b000010: begin sts.push_back(9); rdys.push_back(1'($urandom)); end
      default: begin
        sts.push_back(10); rdys.push_back(1'($urandom));
        sts.push_back(11); rdys.push_back(1'($urandom));
      end
    endcase
    for (int c = 0; c < sts.size(); c++) begin
      opcode = (c <= fw) ? 6'($urandom) : op;
      mem_ready = rdys[c];
      zero = 1'($urandom);
      #1;
      total++;
      if (state !== 4'(sts[c]) || ctrl !== exp_ctrl(sts[c], rdys[c])) begin
        bad++;
        $display("FAIL %s cycle %0d: state=%0d ctrl=%h, required state=%0d ctrl=%h",
                 name, c, state, ctrl, sts[c], exp_ctrl(sts[c], rdys[c]));
      end
      @(posedge clk); #1;
    end
    model_instret = (model_instret + 1) % (1 << CntW);
    total++;
    if (instret !== CntW'(model_instret) || illegal_op !== 1'b0 || bus_error !== 1'b0 ||
        state !== 4'd0) begin
      bad++;
      $display("FAIL %s retire: instret=%0d ill=%b bus=%b state=%0d, required %0d 0 0 0",
               name, instret, illegal_op, bus_error, state, model_instret);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #2;
    total++;
    if (state !== 4'd0 || ctrl !== 17'd0 || instret !== '0 || illegal_op !== 1'b0 ||
        bus_error !== 1'b0) begin
      bad++;
      $display("FAIL reset: state=%0d ctrl=%h instret=%0d ill=%b bus=%b, required all 0",
               state, ctrl, instret, illegal_op, bus_error);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_r_type();
    apply_reset();
    run_instr(6'b000000, 0, 0, "r_type");
  endtask

  task automatic test_lw_wait();
    run_instr(6'b100011, 0, 3, "lw_wait");
  endtask

  task automatic test_back_to_back();
    apply_reset();
    run_instr(6'b101011, 0, 0, "sw");
    run_instr(6'b000100, 0, 0, "beq");
    run_instr(6'b000010, 0, 0, "j");
    total++;
    if (instret !== CntW'(3)) begin
      bad++;
      $display("FAIL back_to_back: instret=%0d, required 3", instret);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    opcode = 6'($urandom);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    opcode = 6'h3f;
    #1;
    total++;
    if (state !== 4'd1 || ctrl !== exp_ctrl(1, 1'b1)) begin
      bad++;
      $display("FAIL illegal decode: state=%0d ctrl=%h, required 1 %h", state, ctrl,
               exp_ctrl(1, 1'b1));
    end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      opcode = 6'($urandom);
      #1;
      total++;
      if (state !== 4'd12 || ctrl !== 17'd0 || illegal_op !== 1'b1 || bus_error !== 1'b0 ||
          instret !== '0) begin
        bad++;
        $display("FAIL illegal trap %0d: state=%0d ctrl=%h ill=%b bus=%b instret=%0d", i,
                 state, ctrl, illegal_op, bus_error, instret);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (state !== 4'd0 || ir_write !== 1'b0) begin
        bad++;
        $display("FAIL timeout fetch wait %0d: state=%0d ir_write=%b, required 0 0", i, state,
                 ir_write);
      end
      @(posedge clk); #1;
    end
    total++;
    if (state !== 4'd12 || bus_error !== 1'b1 || illegal_op !== 1'b0 || ctrl !== 17'd0) begin
      bad++;
      $display("FAIL timeout fetch trap: state=%0d bus=%b ill=%b ctrl=%h, required 12 1 0 0",
               state, bus_error, illegal_op, ctrl);
    end
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      if (i == 3) begin
        total++;
        if (ir_write !== 1'b1 || pc_write !== 1'b1) begin
          bad++;
          $display("FAIL timeout ready at limit: ir_write=%b pc_write=%b, required 1 1",
                   ir_write, pc_write);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (state !== 4'd1 || bus_error !== 1'b0) begin
      bad++;
      $display("FAIL timeout ready wins: state=%0d bus=%b, required 1 0", state, bus_error);
    end
    apply_reset();
    mem_ready = 1'b1;
    @(posedge clk); #1;
    opcode = 6'b100011;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (state !== 4'd3) begin
        bad++;
        $display("FAIL timeout mem_rd wait %0d: state=%0d, required 3", i, state);
      end
      @(posedge clk); #1;
    end
    total++;
    if (state !== 4'd12 || bus_error !== 1'b1 || instret !== '0) begin
      bad++;
      $display("FAIL timeout mem_rd trap: state=%0d bus=%b instret=%0d, required 12 1 0",
               state, bus_error, instret);
    end
  endtask

  task automatic test_reset_abort();
    apply_reset();
    run_instr(6'b001000, 0, 0, "abort_pre");
    opcode = 6'b000000;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    total++;
    if (state !== 4'd6) begin
      bad++;
      $display("FAIL abort setup: state=%0d, required 6", state);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (state !== 4'd0 || ctrl !== 17'd0 || instret !== '0) begin
      bad++;
      $display("FAIL abort async: state=%0d ctrl=%h instret=%0d, required 0 0 0", state, ctrl,
               instret);
    end
    @(posedge clk); #1;
    total++;
    if (state !== 4'd0 || ctrl !== 17'd0 || instret !== '0) begin
      bad++;
      $display("FAIL abort held: state=%0d ctrl=%h instret=%0d, required 0 0 0", state, ctrl,
               instret);
    end
    mem_ready = 1'b0;
    rst_n = 1'b1;
    model_instret = 0;
    run_instr(6'b000000, 1, 0, "abort_post");
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      run_instr(ops[$urandom_range(5, 0)], int'($urandom_range(3, 0)),
                int'($urandom_range(3, 0)), "random");
    end
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the MIPS datapath. Walks each instruction through fetch, decode, execute, memory and write-back states, one state per clock.
- Drives every datapath control strobe from the current state and the latched opcode.
- Waits on a memory ready handshake, counts retired instructions, and traps on illegal opcodes or memory timeout.
- Replaces the purely combinational main control when the datapath runs multi-cycle with a shared instruction/data memory.

Parameters:
- MEM_TIMEOUT, 255, maximum cycles to wait for mem_ready in a memory state before trapping (1..255).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26], taken from the IR output
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if zero
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  latch instruction register
- mem_to_reg  out  1  write-back select: 1=MDR
- reg_dst  out  1  destination select: 1=rd, 0=rt
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0=PC, 1=rs data
- alu_src_b  out  2  0=rt data, 1=const 4, 2=sign-extended imm, 3=imm<<2
- alu_op  out  2  0=add, 1=sub, 2=funct-decoded
- pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target
- state  out  4  current state encoding (debug)
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- instret  out  CNT_W  retired-instruction count
- illegal_op  out  1  sticky; set on an undefined opcode
- bus_error  out  1  sticky; set on a memory timeout

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH(0), instret=0, wait counter=0, illegal_op=0, bus_error=0.
  - All strobes 0, alu_src_b=0, alu_op=0, pc_source=0.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, I_EXEC 10, I_WB 11, TRAP 12.
- Outputs are Moore functions of state, except that pc_write, ir_write and instr_done are additionally gated by mem_ready where noted.
- FETCH:
  - Always: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0.
  - When mem_ready=1: pc_write=1 and ir_write=1, then go to DECODE. Otherwise stay.
- DECODE:
  - Always: alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute). This state is never stalled.
  - Next state by opcode:
    - 000000 -> R_EXEC
    - 100011 or 101011 -> MEM_ADDR
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 001000 -> I_EXEC
    - any other opcode -> TRAP, and set illegal_op.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0. Go to MEM_RD if lw, else MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Go to MEM_WB when mem_ready=1.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
- MEM_WR: mem_write=1, i_or_d=1. When mem_ready=1, go to FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. Go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=2, alu_op=0. Go to I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1. Go to FETCH.
  - The pc_write_cond&zero combination is formed in the datapath, not here.
- JUMP: pc_write=1, pc_source=2. Go to FETCH.
- instr_done:
  - Pulses 1 in MEM_WB, R_WB, I_WB, BRANCH and JUMP.
  - Pulses 1 in MEM_WR only in the cycle mem_ready=1.
  - instret increments by 1 on each pulse and wraps modulo 2^CNT_W with no flag.
- Latency in cycles with zero wait states: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Memory timeout:
  - The wait counter clears on entry to FETCH, MEM_RD and MEM_WR.
  - It increments each cycle spent in one of those states with mem_ready=0.
  - When it reaches MEM_TIMEOUT while mem_ready=0, go to TRAP and set bus_error.
  - mem_ready=1 in the same cycle as the limit wins: the access completes normally.
- TRAP:
  - All strobes 0. The state is terminal until rst_n is asserted.
  - mem_ready and opcode are ignored.
- mem_ready asserted in a state that makes no memory request is ignored.
- Reset asserted mid-instruction aborts it immediately: no strobe is issued after rst_n falls, and instret is not incremented for the aborted instruction.

Test Plan:
- Reset, then fetch with opcode=000000 and mem_ready tied to 1:
  - States step 0,1,6,7,0.
  - reg_write=1 and reg_dst=1 in state 7; instr_done pulses once; instret=1.
- lw (100011) with mem_ready low for 3 cycles in MEM_RD:
  - Stays in state 3 for 4 cycles, then passes through 4 to 0.
  - mem_to_reg=1 in state 4; 8 cycles total.
- sw then beq then j, mem_ready=1:
  - sw: mem_write pulses once in state 5.
  - beq: pc_write_cond=1 and pc_source=1 in state 8.
  - j: pc_write=1 and pc_source=2 in state 9.
  - instret=3.
- Opcode 111111 at DECODE:
  - state=12 and illegal_op=1.
  - All strobes stay 0 for 20 cycles even when mem_ready toggles.
- MEM_TIMEOUT=4 with mem_ready held 0 in FETCH:
  - After 4 wait cycles, state=12 and bus_error=1.
  - Repeat with mem_ready=1 on the 4th cycle: ir_write=1 and state=1.
- rst_n pulsed low in the middle of R_EXEC:
  - Outputs go to reset values asynchronously, state=0.
  - instret holds 0 (reset value); the interrupted instruction is not counted.
